sr_ff_bank_sequencer: RTL
=========================

Name: sr_ff_bank_sequencer

Overview:
Shares a bank of NUM_FF master-slave SR flip-flops between NUM_REQ requesters. Each requester posts a set/reset/toggle/hold command for one flip-flop index. The block arbitrates round-robin and sequences the s/r pulse and a release phase. It never drives s=r=1, then reads back q and acknowledges. It sits between control logic and the flip-flop bank; the bank is clocked by the same clk.

Parameters:
NUM_FF, 8, number of SR flip-flops in the bank
NUM_REQ, 4, number of requesters (>=2)
HOLD_CYC, 2, cycles s or r is held asserted (>=1)
IW, 3, index width, $clog2(NUM_FF)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester command valid
req_op  input  2*NUM_REQ  per-requester op: 00 set, 01 reset, 10 toggle, 11 hold (no drive)
req_idx  input  IW*NUM_REQ  per-requester target flip-flop index
req_ack  output  NUM_REQ  one-cycle completion pulse to granted requester
ff_s  output  NUM_FF  set inputs to bank
ff_r  output  NUM_FF  reset inputs to bank
ff_q  input  NUM_FF  q readback from bank
busy  output  1  high in any state other than IDLE
err_idx  output  1  one-cycle pulse: granted idx >= NUM_FF
err_mismatch  output  1  sticky: readback != expected; cleared only by reset

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ff_s=0, ff_r=0, req_ack=0, busy=0, err_idx=0, err_mismatch=0, rr pointer=0. Outputs go to 0 immediately, not at the next edge. A reset mid-command abandons the command with no ack.
- FSM states: IDLE, DRIVE, RELEASE, CHECK.
- IDLE: if any req_valid, grant the first valid requester searching from pointer upward with wrap. Latch op, idx and grant id.
  - Latch expected value: set->1, reset->0, toggle->~ff_q[idx] sampled at the grant edge.
  - Set/reset/toggle with idx<NUM_FF: go to DRIVE.
  - Hold, or idx>=NUM_FF: go directly to CHECK.
- DRIVE: for HOLD_CYC cycles, exactly one bit is asserted, at the latched idx.
  - Asserted bit is ff_s[idx] if expected=1, else ff_r[idx].
  - All other bits are 0. Internal counter runs HOLD_CYC-1 down to 0, then go to RELEASE.
- RELEASE: ff_s=ff_r=0 for one cycle, so the master-slave sees 0/0 and holds. Then go to CHECK.
- CHECK (one cycle):
  - req_ack[grant]=1.
  - If driven: compare ff_q[idx] with expected; on mismatch set err_mismatch.
  - If idx out of range: err_idx=1 this cycle; no compare, no drive.
  - Hold op: ack only.
  - pointer <= (grant+1) mod NUM_REQ. Next state is IDLE.
- Latency from grant edge to ack: HOLD_CYC+2 cycles for a driven op; 1 cycle for hold or bad idx. Minimum gap between consecutive grants is one IDLE cycle.
- Invariants:
  - ff_s & ff_r == 0 in every cycle.
  - At most one bit of ff_s|ff_r is set.
  - req_ack is one-hot or zero.
- Handshake:
  - A requester holds req_valid, op and idx stable until its ack.
  - Dropping req_valid before ack does not abort the command; it still completes and acks.
  - A requester that keeps req_valid high after ack is treated as a new command at the next arbitration.
- Simultaneous requests are resolved solely by the rr pointer, so no requester waits more than NUM_REQ-1 other commands.
- Only requesters' valid/op/idx are sampled in IDLE; changes during DRIVE/RELEASE/CHECK are ignored.

Test Plan:
- Reset then single set: req0 op=00 idx=5, q[5]=0. Expect ff_s=8'h20 for 2 cycles, then 8'h00 for 1 cycle, then req_ack=4'b0001 with q[5]=1 and err_mismatch=0. busy is high for 4 cycles.
- Toggle: q[2]=1, req1 op=10 idx=2. Expect ff_r=8'h04 for 2 cycles, then ack on req_ack[1], with q[2]=0.
- Round-robin: all four requesters valid with distinct idx 0..3, held until ack. Grants occur in order 0,1,2,3; then with req0 and req2 re-requesting, order is 0 then 2. Each ack is separated by 5 cycles.
- Error paths:
  - NUM_FF=6, idx=7: err_idx pulses with ack after 1 cycle, and ff_s/ff_r stay 0.
  - Bank model with q stuck at 0 and a set on idx 1: err_mismatch rises at CHECK and stays high until rst_n is low.
- Reset mid-DRIVE: assert rst_n=0 while ff_s=8'h01. ff_s drops to 0 with no clock edge, no ack is issued, and after release the pointer is 0.
- Safety: random ops and valids over 10k cycles, with assertions that ff_s&ff_r==0, popcount(ff_s|ff_r)<=1, and req_ack is one-hot or zero.

Source files
------------

// File: rtl/sr_ff_bank_sequencer.sv
// Round-robin sequencer that shares a bank of master-slave SR flip-flops.
// Drives one s/r pulse, releases to 0/0, then reads q back and acks.
module sr_ff_bank_sequencer #(
    parameter int NUM_FF   = 8,
    parameter int NUM_REQ  = 4,
    parameter int HOLD_CYC = 2,
    parameter int IW       = $clog2(NUM_FF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [IW*NUM_REQ-1:0]  req_idx,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_FF-1:0]      ff_s,
    output logic [NUM_FF-1:0]      ff_r,
    input  logic [NUM_FF-1:0]      ff_q,
    output logic                   busy,
    output logic                   err_idx,
    output logic                   err_mismatch
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_CYC + 1);
    localparam logic [IW:0] P_LIM = (IW + 1)'(NUM_FF);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RELEASE,
        CHECK
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_ptr;
    logic [GW-1:0]       r_gnt;
    logic [IW-1:0]       r_idx;
    logic                r_exp;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_FF-1:0]   r_s;
    logic [NUM_FF-1:0]   r_r;
    logic                r_err_idx;
    logic                r_err_mm;

    logic                w_any;
    logic [GW-1:0]       w_gnt;
    logic [1:0]          w_op;
    logic [IW-1:0]       w_idx;
    logic                w_bad;
    logic                w_drv;
    logic                w_exp;
    logic                w_q_new;
    logic                w_q_cur;
    logic [NUM_FF-1:0]   w_hot;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && req_valid[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_any = 1'b1;
                w_gnt = GW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_op  = req_op[2*int'(w_gnt) +: 2];
    assign w_idx = req_idx[IW*int'(w_gnt) +: IW];
    assign w_bad = ({1'b0, w_idx} >= P_LIM);
    assign w_drv = !w_bad && (w_op != 2'b11);
    assign w_hot = {{(NUM_FF-1){1'b0}}, 1'b1} << w_idx;

    always_comb begin
        w_q_new = 1'b0;
        w_q_cur = 1'b0;
        for (int i = 0; i < NUM_FF; i++) begin
            if (w_idx == IW'(i)) w_q_new = ff_q[i];
            if (r_idx == IW'(i)) w_q_cur = ff_q[i];
        end
    end

    always_comb begin
        case (w_op)
            2'b00:   w_exp = 1'b1;
            2'b10:   w_exp = ~w_q_new;
            default: w_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_exp     <= 1'b0;
            r_cnt     <= '0;
            r_ack     <= '0;
            r_s       <= '0;
            r_r       <= '0;
            r_err_idx <= 1'b0;
            r_err_mm  <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_err_idx <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_gnt;
                        r_idx <= w_idx;
                        r_exp <= w_exp;
                        if (w_drv) begin
                            r_state <= DRIVE;
                            r_cnt   <= CW'(HOLD_CYC - 1);
                            if (w_exp) r_s <= w_hot;
                            else       r_r <= w_hot;
                        end else begin
                            r_state   <= CHECK;
                            r_ack     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt;
                            r_err_idx <= w_bad;
                        end
                    end
                end
                DRIVE: begin
                    if (r_cnt == '0) begin
                        r_s     <= '0;
                        r_r     <= '0;
                        r_state <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    // q is settled after the pulse; flag lands with the ack.
                    r_state <= CHECK;
                    r_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gnt;
                    if (w_q_cur != r_exp) r_err_mm <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ptr   <= (r_gnt == GW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
                end
            endcase
        end
    end

    assign req_ack      = r_ack;
    assign ff_s         = r_s;
    assign ff_r         = r_r;
    assign busy         = (r_state != IDLE);
    assign err_idx      = r_err_idx;
    assign err_mismatch = r_err_mm;

endmodule
